// File: rtl/buffer_burst_arbiter.sv
`default_nettype none
// ============================================================================
//  Module   : buffer_burst_arbiter
//  Purpose  : Arbitrates burst reads of a shared buffer among NumReq routers
//             and returns the beats to the owner. The buffer has one cycle of
//             read latency. Round-robin selection is used when
//             ARB_ROUND_ROBIN_EN is defined. Otherwise the lowest index wins.
//  Revision : 1.0 - initial release
// ============================================================================
module buffer_burst_arbiter #(
    parameter int NumReq    = 4,
    parameter int Depth     = 32,
    parameter int DataWidth = 8,
    parameter int MaxWidth  = 9,
    parameter int AddrWidth = $clog2(Depth),
    parameter int LenWidth  = $clog2(MaxWidth + 1),
    parameter int IdxWidth  = $clog2(MaxWidth)
) (
    input  logic                          clk,
    input  logic                          rst_n,
    input  logic [NumReq-1:0]             reqEn,
    input  logic [NumReq*AddrWidth-1:0]   reqAddr,
    input  logic [NumReq*LenWidth-1:0]    reqLen,
    output logic [NumReq-1:0]             grant,
    output logic                          bufReadEn,
    output logic [AddrWidth-1:0]          bufReadAddr,
    input  logic [DataWidth-1:0]          bufDataIn,
    output logic [DataWidth-1:0]          dataOut,
    output logic [IdxWidth-1:0]           dataIdx,
    output logic [NumReq-1:0]             dataValid,
    output logic [NumReq-1:0]             done
);

    localparam int c_ptr_width = (NumReq > 1) ? $clog2(NumReq) : 1;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        BURST = 2'd1,
        DRAIN = 2'd2
    } state_t;

    state_t                   state_q, state_d;
    logic [c_ptr_width-1:0]   ptr_q, ptr_d;
    logic [NumReq-1:0]        grant_q, grant_d;
    logic [AddrWidth-1:0]     addr_q, addr_d;
    logic [LenWidth-1:0]      rem_q, rem_d;
    logic [IdxWidth-1:0]      idx_q, idx_d;
    logic                     zlen_q, zlen_d;
    // Stage 1: beat issued last cycle, its read data arrives this cycle
    logic                     v1_q, v1_d;
    logic                     last1_q, last1_d;
    logic [IdxWidth-1:0]      idx1_q, idx1_d;
    // Stage 2: registered outputs
    logic [DataWidth-1:0]     dout_q, dout_d;
    logic [IdxWidth-1:0]      didx_q, didx_d;
    logic [NumReq-1:0]        dvalid_q, dvalid_d;
    logic [NumReq-1:0]        done_q, done_d;

    logic [AddrWidth-1:0]     w_req_addr [NumReq];
    logic [LenWidth-1:0]      w_req_len  [NumReq];
    logic                     w_win_found;
    logic [c_ptr_width-1:0]   w_win_idx;

    generate
        for (genvar gi = 0; gi < NumReq; gi++) begin : g_unpack
            logic [LenWidth-1:0] w_raw_len;
            assign w_raw_len      = reqLen[gi*LenWidth +: LenWidth];
            assign w_req_addr[gi] = reqAddr[gi*AddrWidth +: AddrWidth];
            assign w_req_len[gi]  = (w_raw_len > LenWidth'(MaxWidth)) ?
                                    LenWidth'(MaxWidth) : w_raw_len;
        end
    endgenerate

    // Search begins at ptr_q; in fixed-priority builds ptr_q never leaves 0.
    always_comb begin
        int cand;
        logic [c_ptr_width-1:0] cand_idx;
        cand        = 0;
        cand_idx    = '0;
        w_win_found = 1'b0;
        w_win_idx   = '0;
        for (int i = 0; i < NumReq; i++) begin
            cand = int'(ptr_q) + i;
            if (cand >= NumReq) begin
                cand = cand - NumReq;
            end
            cand_idx = c_ptr_width'(cand);
            if (!w_win_found && reqEn[cand_idx]) begin
                w_win_found = 1'b1;
                w_win_idx   = cand_idx;
            end
        end
    end

    always_comb begin
        state_d  = state_q;
        ptr_d    = ptr_q;
        grant_d  = grant_q;
        addr_d   = addr_q;
        rem_d    = rem_q;
        idx_d    = idx_q;
        zlen_d   = zlen_q;
        v1_d     = 1'b0;
        last1_d  = 1'b0;
        idx1_d   = idx_q;
        dout_d   = dout_q;
        didx_d   = didx_q;
        dvalid_d = v1_q ? grant_q : '0;
        done_d   = last1_q ? grant_q : '0;
        if (v1_q) begin
            dout_d = bufDataIn;
            didx_d = idx1_q;
        end
        // Ownership ends on the cycle the done pulse becomes visible.
        if (last1_q) begin
            grant_d = '0;
        end

        case (state_q)
            IDLE: begin
                // Wait until the previous owner has seen its done pulse.
                if (w_win_found && (grant_q == '0) && (done_q == '0)) begin
                    grant_d = NumReq'(1) << w_win_idx;
                    addr_d  = w_req_addr[w_win_idx];
                    rem_d   = w_req_len[w_win_idx];
                    idx_d   = '0;
                    zlen_d  = (w_req_len[w_win_idx] == '0);
                    state_d = (w_req_len[w_win_idx] == '0) ? DRAIN : BURST;
`ifdef ARB_ROUND_ROBIN_EN
                    ptr_d   = (int'(w_win_idx) == NumReq - 1) ? '0 :
                              w_win_idx + c_ptr_width'(1);
`endif
                end
            end
            BURST: begin
                v1_d    = 1'b1;
                last1_d = (rem_q == LenWidth'(1));
                addr_d  = (addr_q == AddrWidth'(Depth - 1)) ? '0 :
                          addr_q + AddrWidth'(1);
                rem_d   = rem_q - LenWidth'(1);
                idx_d   = idx_q + IdxWidth'(1);
                if (rem_q == LenWidth'(1)) begin
                    state_d = DRAIN;
                end
            end
            DRAIN: begin
                // A zero-length burst injects a data-less last token here.
                last1_d = zlen_q;
                zlen_d  = 1'b0;
                state_d = IDLE;
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            ptr_q    <= '0;
            grant_q  <= '0;
            addr_q   <= '0;
            rem_q    <= '0;
            idx_q    <= '0;
            zlen_q   <= 1'b0;
            v1_q     <= 1'b0;
            last1_q  <= 1'b0;
            idx1_q   <= '0;
            dout_q   <= '0;
            didx_q   <= '0;
            dvalid_q <= '0;
            done_q   <= '0;
        end else begin
            ptr_q    <= ptr_d;
            grant_q  <= grant_d;
            addr_q   <= addr_d;
            rem_q    <= rem_d;
            idx_q    <= idx_d;
            zlen_q   <= zlen_d;
            v1_q     <= v1_d;
            last1_q  <= last1_d;
            idx1_q   <= idx1_d;
            dout_q   <= dout_d;
            didx_q   <= didx_d;
            dvalid_q <= dvalid_d;
            done_q   <= done_d;
        end
    end

    assign grant       = grant_q;
    assign bufReadEn   = (state_q == BURST);
    assign bufReadAddr = addr_q;
    assign dataOut     = dout_q;
    assign dataIdx     = didx_q;
    assign dataValid   = dvalid_q;
    assign done        = done_q;

endmodule

`default_nettype wire

// File: tb/tb_buffer_burst_arbiter.sv
`default_nettype none
// ============================================================================
//  Module   : tb_buffer_burst_arbiter
//  Purpose  : Scoreboard bench for buffer_burst_arbiter; follows the
//             ARB_ROUND_ROBIN_EN setting of the build.
//  Revision : 1.0 - initial release
// ============================================================================
module tb_buffer_burst_arbiter;

    localparam int NumReq = 4, AddrWidth = 5, LenWidth = 4, IdxWidth = 4;

    logic                         clk = 1'b0;
    logic                         rst_n = 1'b0;
    logic [NumReq-1:0]            reqEn = '0;
    logic [NumReq*AddrWidth-1:0]  reqAddr = '0;
    logic [NumReq*LenWidth-1:0]   reqLen = '0;
    logic [NumReq-1:0]            grant;
    logic                         bufReadEn;
    logic [AddrWidth-1:0]         bufReadAddr;
    logic [7:0]                   bufDataIn = '0;
    logic [7:0]                   dataOut;
    logic [IdxWidth-1:0]          dataIdx;
    logic [NumReq-1:0]            dataValid;
    logic [NumReq-1:0]            done;

    buffer_burst_arbiter dut (
        .clk         (clk),
        .rst_n       (rst_n),
        .reqEn       (reqEn),
        .reqAddr     (reqAddr),
        .reqLen      (reqLen),
        .grant       (grant),
        .bufReadEn   (bufReadEn),
        .bufReadAddr (bufReadAddr),
        .bufDataIn   (bufDataIn),
        .dataOut     (dataOut),
        .dataIdx     (dataIdx),
        .dataValid   (dataValid),
        .done        (done)
    );

    always #5 clk = ~clk;

    // Buffer model: buffer[k] = k, one cycle read latency
    always @(posedge clk) begin
        if (bufReadEn) bufDataIn <= 8'(bufReadAddr);
    end

    typedef struct { logic [3:0] own; int data; int idx; } beat_t;
    typedef struct { logic [3:0] g; int lat; } gnt_t;

    int    addr_sb[$];
    beat_t beat_sb[$];
    gnt_t  gnt_sb[$];

    int checks = 0;
    int errors = 0;
    int cyc = 0;
    int gcount = 0;
    int gcyc = 0;
    int glat = 0;
    logic [3:0] gown = '0;
    bit   gpend = 1'b0;
    bit   gap_chk = 1'b0;
    int   last_done = -1;
    logic prev_ren = 1'b0;
    logic [3:0] prev_grant = '0;

    task automatic chk(input string nm, input int act, input int exp);
        checks++;
        if (act != exp) begin
            errors++;
            $display("FAIL %s: got %0d expected %0d (cycle %0d)", nm, act, exp, cyc);
        end
    endtask

    always @(posedge clk) cyc <= cyc + 1;

    // Monitor: pops expectations whenever the DUT presents activity
    always @(negedge clk) begin
        if (rst_n) begin
            gnt_t  ge;
            beat_t be;
            chk("onehot", int'($onehot0(grant) && $onehot0(dataValid) && $onehot0(done)), 1);
            if (bufReadEn) begin
                if (addr_sb.size() == 0) chk("rd_unexpected", 1, 0);
                else chk("rd_addr", int'(bufReadAddr), addr_sb.pop_front());
                if (!prev_ren && gap_chk && last_done >= 0)
                    chk("burst_gap", cyc - last_done, 2);
            end
            if (dataValid != '0) begin
                if (beat_sb.size() == 0) chk("dv_unexpected", int'(dataValid), 0);
                else begin
                    be = beat_sb.pop_front();
                    chk("dv_owner", int'(dataValid), int'(be.own));
                    chk("dv_data", int'(dataOut), be.data);
                    chk("dv_idx", int'(dataIdx), be.idx);
                end
            end
            if (grant != '0 && prev_grant == '0) begin
                if (gnt_sb.size() == 0) chk("grant_unexpected", int'(grant), 0);
                else begin
                    ge = gnt_sb.pop_front();
                    chk("grant", int'(grant), int'(ge.g));
                    gown = ge.g;
                    glat = ge.lat;
                    gcyc = cyc;
                    gpend = 1'b1;
                    gcount++;
                end
            end
            if (done != '0) begin
                if (!gpend) chk("done_unexpected", int'(done), 0);
                else begin
                    chk("done_owner", int'(done), int'(gown));
                    chk("done_latency", cyc - gcyc, glat);
                    chk("grant_clear_on_done", int'(grant), 0);
                    gpend = 1'b0;
                end
                last_done = cyc;
            end
            prev_ren = bufReadEn;
            prev_grant = grant;
        end else begin
            prev_ren = 1'b0;
            prev_grant = '0;
        end
    end

    task automatic set_req(input int r, input int addr, input int len);
        reqAddr[r*AddrWidth +: AddrWidth] = AddrWidth'(addr);
        reqLen[r*LenWidth +: LenWidth] = LenWidth'(len);
    endtask

    task automatic push_grant(input logic [3:0] g, input int lat);
        gnt_t e;
        e.g = g;
        e.lat = lat;
        gnt_sb.push_back(e);
    endtask

    task automatic push_beat(input logic [3:0] g, input int addr, input int data, input int idx);
        beat_t b;
        addr_sb.push_back(addr);
        b.own = g;
        b.data = data;
        b.idx = idx;
        beat_sb.push_back(b);
    endtask

    task automatic pulse_req(input logic [3:0] mask);
        @(negedge clk);
        reqEn = mask;
        @(negedge clk);
        reqEn = '0;
    endtask

    task automatic wait_idle(input string nm);
        int n = 0;
        while ((addr_sb.size() != 0 || beat_sb.size() != 0 || gnt_sb.size() != 0 || gpend) && n < 300) begin
            @(negedge clk);
            n++;
        end
        chk({nm, "_complete"}, int'(n < 300), 1);
        repeat (3) @(negedge clk);
    endtask

    task automatic check_zero(input string nm);
        chk({nm, "_grant"}, int'(grant), 0);
        chk({nm, "_dataValid"}, int'(dataValid), 0);
        chk({nm, "_done"}, int'(done), 0);
        chk({nm, "_bufReadEn"}, int'(bufReadEn), 0);
        chk({nm, "_bufReadAddr"}, int'(bufReadAddr), 0);
        chk({nm, "_dataOut"}, int'(dataOut), 0);
        chk({nm, "_dataIdx"}, int'(dataIdx), 0);
    endtask

    initial begin
        int wrap_addr [4];
        int wrap_data [4];
        int order [5];
        logic [3:0] mask;
        int base;
        int n;
        wrap_addr = '{30, 31, 0, 1};
        wrap_data = '{8'h1E, 8'h1F, 8'h00, 8'h01};
`ifdef ARB_ROUND_ROBIN_EN
        order = '{0, 1, 2, 3, 0};
        mask = 4'b1111;
`else
        order = '{1, 1, 1, 1, 1};
        mask = 4'b0110;
`endif

        #1 check_zero("reset");
        repeat (3) @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);
        chk("post_reset_no_read", int'(bufReadEn), 0);

        // Single request: addresses 5..13, data 05..0D
        set_req(0, 5, 9);
        push_grant(4'b0001, 10);
        for (int k = 0; k < 9; k++) push_beat(4'b0001, 5 + k, 5 + k, k);
        pulse_req(4'b0001);
        wait_idle("single");

        // Address wrap at the buffer end
        set_req(2, 30, 4);
        push_grant(4'b0100, 5);
        for (int k = 0; k < 4; k++) push_beat(4'b0100, wrap_addr[k], wrap_data[k], k);
        pulse_req(4'b0100);
        wait_idle("wrap");

        // Zero length: no reads, done two cycles after grant
        set_req(2, 3, 0);
        push_grant(4'b0100, 2);
        pulse_req(4'b0100);
        wait_idle("zero_len");

        // Oversize length clamps to 9 beats
        set_req(3, 0, 15);
        push_grant(4'b1000, 10);
        for (int k = 0; k < 9; k++) push_beat(4'b1000, k, k, k);
        pulse_req(4'b1000);
        wait_idle("clamp");

        // Contention with requests held, all lengths 2
        for (int i = 0; i < NumReq; i++) set_req(i, 8 * i, 2);
        for (int k = 0; k < 5; k++) begin
            push_grant(4'(1 << order[k]), 3);
            push_beat(4'(1 << order[k]), 8 * order[k], 8 * order[k], 0);
            push_beat(4'(1 << order[k]), 8 * order[k] + 1, 8 * order[k] + 1, 1);
        end
        last_done = -1;
        gap_chk = 1'b1;
        base = gcount;
        @(negedge clk);
        reqEn = mask;
        n = 0;
        while (gcount < base + 5 && n < 200) begin
            @(negedge clk);
            n++;
        end
        reqEn = '0;
        chk("contend_grants", gcount - base, 5);
        wait_idle("contend");
        gap_chk = 1'b0;

        // Reset on the third beat of a 9-beat burst
        set_req(0, 0, 9);
        push_grant(4'b0001, 10);
        addr_sb.push_back(0);
        addr_sb.push_back(1);
        @(negedge clk);
        reqEn = 4'b0001;
        @(posedge clk);
        #1 reqEn = '0;
        @(posedge clk);
        @(posedge clk);
        #2 rst_n = 1'b0;
        #1 check_zero("midrst");
        chk("midrst_ptr", int'(dut.ptr_q), 0);
        gpend = 1'b0;
        for (int k = 0; k < 3; k++) begin
            @(negedge clk);
            chk("midrst_no_done", int'(done), 0);
        end
        chk("midrst_sb_empty", addr_sb.size() + beat_sb.size() + gnt_sb.size(), 0);
        rst_n = 1'b1;
        @(negedge clk);
        chk("midrst_no_read_after_release", int'(bufReadEn), 0);

        // Recovery with a single-beat burst
        set_req(1, 7, 1);
        push_grant(4'b0010, 2);
        push_beat(4'b0010, 7, 7, 0);
        pulse_req(4'b0010);
        wait_idle("recover");

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

    initial begin
        #100000;
        $display("FAIL watchdog: got timeout expected completion");
        $fatal(1, "watchdog");
    end

endmodule

`default_nettype wire
